// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA1 message padder and the SHA1 core.
//   - Block/word/length-field geometry and the FIPS 180-4 pad byte.
//   - Padder FSM state encoding.
//   - SHA1 initial hash values (consumed by the core when out_first is set).
//   - mask_pad_word: masks invalid tail bytes and inserts the 0x80 pad byte.
package sha1_pkg;

  localparam int BLOCK_W     = 512;
  localparam int WORD_W      = 32;
  localparam int LEN_FIELD_W = 64;
  localparam int BLK_WORDS   = BLOCK_W / WORD_W;
  localparam int IDX_W       = 4;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  localparam logic [WORD_W-1:0] SHA1_H0 = 32'h67452301;
  localparam logic [WORD_W-1:0] SHA1_H1 = 32'hEFCDAB89;
  localparam logic [WORD_W-1:0] SHA1_H2 = 32'h98BADCFE;
  localparam logic [WORD_W-1:0] SHA1_H3 = 32'h10325476;
  localparam logic [WORD_W-1:0] SHA1_H4 = 32'hC3D2E1F0;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD,
    ST_LEN,
    ST_EMIT,
    ST_EMIT_PAD
  } pad_state_e;

  // Keeps bytes [0, nb) of a big-endian word, zeroes the rest, and on the
  // final word drops the pad byte into byte position nb when it fits.
  function automatic logic [WORD_W-1:0] mask_pad_word(
    input logic [WORD_W-1:0] d,
    input logic [2:0]        nb,
    input logic              last
  );
    logic [WORD_W-1:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(nb)) begin
        w[WORD_W-1-8*b -: 8] = d[WORD_W-1-8*b -: 8];
      end else if (last && (b == int'(nb))) begin
        w[WORD_W-1-8*b -: 8] = PAD_BYTE;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sha1_block_buf.sv
// 16 x 32-bit block buffer for the SHA1 padder.
// Ports:
//   clk       in   clock
//   clear_i   in   synchronous clear of all words
//   wr_en_i   in   write strobe
//   wr_idx_i  in   word index to write (0 = first word)
//   wr_data_i in   word to write
//   block_o   out  flat block, word 0 in the most significant 32 bits
module sha1_block_buf
  import sha1_pkg::*;
(
  input  logic               clk,
  input  logic               clear_i,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [WORD_W-1:0]  wr_data_i,
  output logic [BLOCK_W-1:0] block_o
);

  logic [WORD_W-1:0] mem_q [BLK_WORDS];

  always_ff @(posedge clk) begin
    if (clear_i) begin
      for (int i = 0; i < BLK_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    block_o = '0;
    for (int i = 0; i < BLK_WORDS; i++) begin
      block_o[BLOCK_W-1-WORD_W*i -: WORD_W] = mem_q[i];
    end
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA1 message padder: turns a big-endian 32-bit word stream into complete,
// FIPS 180-4 padded 512-bit blocks for the SHA1 core.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_data/in_valid/in_ready/in_last/in_bytes
//                         message word stream (byte 0 in [31:24]); in_bytes is
//                         4 except on the final word, where it may be 0..4
//   out_block/out_valid/out_ready
//                         padded block (word 0 in [511:480]) with handshake
//   out_first/out_last    block is first / final of its message
//   msg_len_bits          message length in bits, driven while out_last is high
//   busy                  message in flight (first word accepted, last block not yet taken)
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int CNT_W = 61
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [2:0]             in_bytes,
  output logic [BLOCK_W-1:0]     out_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_first,
  output logic                   out_last,
  output logic [LEN_FIELD_W-1:0] msg_len_bits,
  output logic                   busy
);

  pad_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic               pad_pending_q;
  logic               first_q;
  logic               last_q;
  logic               busy_q;

  logic               accept;
  logic               take;
  logic               pad_in_word;
  logic [LEN_FIELD_W-1:0] len_bits;

  logic               wr_en;
  logic [WORD_W-1:0]  wr_data;

  assign accept      = in_valid && in_ready;
  assign take        = out_valid && out_ready;
  // A short final word (including the empty one) has room for the pad byte.
  assign pad_in_word = in_last && (in_bytes < 3'd4);
  // Byte count wraps mod 2^CNT_W; the shift turns bytes into bits.
  assign len_bits    = LEN_FIELD_W'(byte_cnt_q) << 3;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next-state logic ----
  // The pad byte always lands at or before word 13 on the path into LEN;
  // landing in word 14 or 15 leaves no room for the length, so the block is
  // emitted as non-final and padding continues in a fresh block.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (idx_q == 4'd15) begin
            state_d = in_last ? ST_EMIT_PAD : ST_EMIT;
          end else if (in_last) begin
            state_d = (pad_in_word && (idx_q == 4'd13)) ? ST_LEN : ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (idx_q == 4'd13) begin
          state_d = ST_LEN;
        end else if (idx_q == 4'd15) begin
          state_d = ST_EMIT_PAD;
        end
      end
      ST_LEN: begin
        if (idx_q == 4'd15) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d = ST_FILL;
        end
      end
      ST_EMIT_PAD: begin
        if (out_ready) begin
          state_d = ST_PAD;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // ---- output / buffer-write logic ----
  always_comb begin
    in_ready     = (state_q == ST_FILL);
    out_valid    = (state_q == ST_EMIT) || (state_q == ST_EMIT_PAD);
    out_first    = out_valid && first_q;
    out_last     = (state_q == ST_EMIT) && last_q;
    msg_len_bits = out_last ? len_bits : '0;
    busy         = busy_q;
    wr_en        = 1'b0;
    wr_data      = '0;
    unique case (state_q)
      ST_FILL: begin
        wr_en   = accept;
        wr_data = mask_pad_word(in_data, in_bytes, in_last);
      end
      ST_PAD: begin
        wr_en   = 1'b1;
        wr_data = pad_pending_q ? {PAD_BYTE, 24'h0} : '0;
      end
      ST_LEN: begin
        wr_en   = 1'b1;
        wr_data = idx_q[0] ? len_bits[WORD_W-1:0] : len_bits[LEN_FIELD_W-1:WORD_W];
      end
      default: begin
        wr_en   = 1'b0;
        wr_data = '0;
      end
    endcase
  end

  // ---- index, byte counter and message flags ----
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= '0;
      byte_cnt_q    <= '0;
      pad_pending_q <= 1'b0;
      first_q       <= 1'b1;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (accept) begin
            idx_q      <= idx_q + 4'd1;
            byte_cnt_q <= byte_cnt_q + CNT_W'(in_bytes);
            busy_q     <= 1'b1;
            if (in_last && !pad_in_word) begin
              pad_pending_q <= 1'b1;
            end
          end
        end
        ST_PAD: begin
          idx_q         <= idx_q + 4'd1;
          pad_pending_q <= 1'b0;
        end
        ST_LEN: begin
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            last_q <= 1'b1;
          end
        end
        ST_EMIT, ST_EMIT_PAD: begin
          if (take) begin
            idx_q   <= '0;
            first_q <= 1'b0;
            if ((state_q == ST_EMIT) && last_q) begin
              byte_cnt_q <= '0;
              first_q    <= 1'b1;
              last_q     <= 1'b0;
              busy_q     <= 1'b0;
            end
          end
        end
        default: begin
          idx_q <= '0;
        end
      endcase
    end
  end

  // ---- block buffer ----
  sha1_block_buf u_buf (
    .clk       (clk),
    .clear_i   (reset),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i (wr_data),
    .block_o   (out_block)
  );

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Testbench for sha1_msg_padder: directed messages, reference padding model
// feeding an expected-block queue, consumer process popping and comparing.
module tb_sha1_msg_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic [511:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         out_first;
  logic         out_last;
  logic [63:0]  msg_len_bits;
  logic         busy;

  typedef struct packed {
    logic [511:0] blk;
    logic         first;
    logic         last;
    logic [63:0]  len;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         stall_n  = 0;

  always #5 clk = ~clk;

  sha1_msg_padder #(.CNT_W(61)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_bytes     (in_bytes),
    .out_block    (out_block),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_first    (out_first),
    .out_last     (out_last),
    .msg_len_bits (msg_len_bits),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic build_expected();
    logic [7:0]  pad[$];
    logic [63:0] len;
    exp_t        e;
    int          nblk;
    pad = msg_q;
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    len = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) pad.push_back(len[8*i +: 8]);
    nblk = pad.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int k = 0; k < 64; k++) e.blk[511-8*k -: 8] = pad[b*64+k];
      e.first = (b == 0);
      e.last  = (b == nblk-1);
      e.len   = len;
      exp_q.push_back(e);
    end
  endtask

  // Drives msg_q as a word stream; bytes past the valid count carry 0xEE junk.
  task automatic send_msg();
    int n;
    int nw;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d;
      int          g;
      logic        lst;
      d   = '0;
      lst = (w == nw - 1);
      for (int b = 0; b < 4; b++) begin
        if (4*w + b < n) d[31-8*b -: 8] = msg_q[4*w+b];
        else             d[31-8*b -: 8] = 8'hEE;
      end
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      in_last  = lst;
      in_bytes = lst ? 3'(n - 4*w) : 3'd4;
      g = 0;
      while (!in_ready && g < 2000) begin
        @(negedge clk);
        g++;
      end
      chk("in_ready_wait", 512'(g < 2000), 512'(1));
      if (g >= 2000) begin
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
    in_data  = '0;
    chk("in_ready_after_last", 512'(in_ready), 512'(0));
    chk("busy_after_last", 512'(busy), 512'(1));
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("blocks_drained", 512'(exp_q.size()), 512'(0));
    @(negedge clk);
    @(negedge clk);
    chk("busy_idle", 512'(busy), 512'(0));
    chk("in_ready_idle", 512'(in_ready), 512'(1));
    chk("out_valid_idle", 512'(out_valid), 512'(0));
  endtask

  task automatic run_msg();
    build_expected();
    send_msg();
    wait_done();
  endtask

  task automatic load_pattern(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'(i*13 + 1));
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  // Consumer: optional back-pressure, then pops the scoreboard and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (stall_n > 0) begin
          out_ready = 1'b0;
          repeat (stall_n) @(negedge clk);
          chk("stall_valid_held", 512'(out_valid), 512'(1));
          chk("stall_in_ready_low", 512'(in_ready), 512'(0));
          if (exp_q.size() != 0) chk("stall_block_stable", out_block, exp_q[0].blk);
        end
        chk("block_expected", 512'(exp_q.size() != 0), 512'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("block", out_block, e.blk);
          chk("first", 512'(out_first), 512'(e.first));
          chk("last", 512'(out_last), 512'(e.last));
          if (e.last) chk("len", 512'(msg_len_bits), 512'(e.len));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop_after_take", 512'(out_valid), 512'(0));
        out_ready = (stall_n == 0);
      end
    end
  end

  initial begin
    int lens[9];
    lens = '{0, 52, 53, 55, 56, 60, 61, 63, 64};
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = 3'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_out_block", out_block, 512'(0));
    chk("rst_out_first", 512'(out_first), 512'(0));
    chk("rst_out_last", 512'(out_last), 512'(0));
    chk("rst_len", 512'(msg_len_bits), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));

    load_abc();
    run_msg();

    foreach (lens[i]) begin
      load_pattern(lens[i]);
      run_msg();
    end

    stall_n   = 20;
    out_ready = 1'b0;
    load_pattern(119);
    run_msg();
    stall_n   = 0;
    out_ready = 1'b1;

    // Message A is abandoned by reset while the padder is zero-filling.
    load_pattern(20);
    send_msg();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_out_valid", 512'(out_valid), 512'(0));
    chk("mid_rst_in_ready", 512'(in_ready), 512'(1));
    chk("mid_rst_busy", 512'(busy), 512'(0));
    chk("mid_rst_out_block", out_block, 512'(0));
    load_abc();
    run_msg();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
